// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the RV32I multicycle controller.
//   - state_t     : FSM state encoding (4 bits)
//   - OP_*        : supported opcodes
//   - ALU_*       : ALUControl codes
//   - SRCA_/SRCB_/RES_/IMM_ : datapath select codes
//   - ALUOP_*     : main-decoder to ALU-decoder codes
//   - ctrl_t / state_ctrl() : Moore control word for each state
//   - imm_src() / op_supported() : opcode-only helpers
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       mem_wait;   // state waits on the memory handshake
        logic       is_decode;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURES;
                c.mem_wait   = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.is_decode = 1'b1;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.adr_src  = 1'b1;
                c.mem_wait = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
                c.mem_wait  = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            S_LUI: begin
                c.alu_src_a = SRCA_ZERO;
                c.alu_src_b = SRCB_IMM;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BRANCH, OP_JAL, OP_LUI: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/aludec.sv
// aludec: ALU decoder shared with the single-cycle controller.
// Ports:
//   alu_op      in  2  main-decoder ALUOp (00 add, 01 sub, 10 by funct3)
//   funct3      in  3  Instr[14:12]
//   op5         in  1  Instr[5] (distinguishes R-type from I-type)
//   funct7b5    in  1  Instr[30]
//   alu_control out 3  ALU operation code
module aludec
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type with funct7b5 is sub; addi ignores bit 30.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore sequencing FSM for the RV32I multicycle core.
// Optional feature macro: MC_CTRL_MEM_READY_EN (adds MemReady handshake).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   op, funct3, funct7b5       instruction fields from the IR
//   Zero, blt, bltu            branch flags from the datapath
//   MemReady                   memory accept (only with MC_CTRL_MEM_READY_EN)
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  datapath strobes/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc  datapath selects
//   Illegal                    pulse in DECODE for an unsupported opcode
module mc_controller
    import mc_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       blt,
    input  logic       bltu,
`ifdef MC_CTRL_MEM_READY_EN
    input  logic       MemReady,
`endif
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   mem_ready;
    logic   mem_go;
    logic   taken;

`ifdef MC_CTRL_MEM_READY_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // States that touch memory advance only once the access is accepted.
    assign mem_go = ~ctrl.mem_wait | mem_ready;

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_go) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_LUI:            state_next = S_LUI;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_go) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_go) state_next = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LUI: state_next = S_ALUWB;
            S_ALUWB, S_BRANCH: state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state so outputs come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESET_STATE;
            ctrl  <= state_ctrl(RESET_STATE);
        end else begin
            state <= state_next;
            ctrl  <= state_ctrl(state_next);
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = ~Zero;
            3'b100:  taken = blt;
            3'b101:  taken = ~blt;
            3'b110:  taken = bltu;
            3'b111:  taken = ~bltu;
            default: taken = 1'b0;
        endcase
    end

    aludec u_aludec (
        .alu_op      (ctrl.alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

    // Strobes are masked by reset so an asynchronous reset mid-instruction
    // cannot produce a write in the cycle it lands in.
    assign PCWrite   = ((ctrl.pc_update & mem_go) | (ctrl.branch & taken)) & ~reset;
    assign IRWrite   = ctrl.ir_write & mem_go & ~reset;
    assign MemWrite  = ctrl.mem_write & ~reset;
    assign RegWrite  = ctrl.reg_write & ~reset;
    assign AdrSrc    = ctrl.adr_src;
    assign ResultSrc = ctrl.result_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ImmSrc    = imm_src(op);
    assign Illegal   = ctrl.is_decode & ~op_supported(op);

endmodule
